mul8_seq_ctrl: RTL



---
 rtl/mul8_seq_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mul8_seq_ctrl.sv
// Sequencer producing an unsigned 8x8 product by running one external 4x4 multiplier over up to four steps.
// Optional build macro MUL8_SEQ_ZERO_SKIP_EN: skip steps whose nibble pair contains a zero.
module mul8_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic        mul_active,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic        busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid and out_product are held stable until that transfer completes.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  a_q, b_q;
  logic [1:0]  step, step_nx, first_step;
  logic [15:0] acc, partial, sum;
  logic        last, active;
  logic [3:0]  a_sel, b_sel;

  // Step bit 0 picks the high nibble of A, step bit 1 the high nibble of B.
  assign a_sel = step[0] ? a_q[7:4] : a_q[3:0];
  assign b_sel = step[1] ? b_q[7:4] : b_q[3:0];

`ifdef MUL8_SEQ_ZERO_SKIP_EN
  logic [3:0] mask, in_mask;

  always_comb begin
    in_mask[0] = (|in_a[3:0]) & (|in_b[3:0]);
    in_mask[1] = (|in_a[7:4]) & (|in_b[3:0]);
    in_mask[2] = (|in_a[3:0]) & (|in_b[7:4]);
    in_mask[3] = (|in_a[7:4]) & (|in_b[7:4]);
  end

  // Lowest set bit wins because the loop walks downward.
  always_comb begin
    first_step = 2'd0;
    step_nx    = step;
    last       = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (in_mask[i]) first_step = 2'(i);
      if (mask[i] && (i > int'(step))) begin
        step_nx = 2'(i);
        last    = 1'b0;
      end
    end
  end

  // An all-zero mask still spends one idle RUN cycle so the result lands at E1.
  assign active = (state == RUN) && mask[step];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             mask <= 4'd0;
    else if (state == IDLE && in_valid)  mask <= in_mask;
  end
`else
  assign first_step = 2'd0;
  assign step_nx    = step + 2'd1;
  assign last       = (step == 2'd3);
  assign active     = (state == RUN);
`endif

  always_comb begin
    partial = 16'd0;
    case (step)
      2'd0:    partial = {8'd0, mul_p};
      2'd1,
      2'd2:    partial = {4'd0, mul_p, 4'd0};
      default: partial = {mul_p, 8'd0};
    endcase
    sum = acc + (active ? partial : 16'd0);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      acc         <= 16'd0;
      step        <= 2'd0;
      out_product <= 16'd0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q  <= in_a;
          b_q  <= in_b;
          acc  <= 16'd0;
          step <= first_step;
        end
        RUN: begin
          acc  <= sum;
          step <= last ? 2'd0 : step_nx;
          if (last) begin
            out_product <= sum;
            out_valid   <= 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign mul_active = active;
  assign mul_a      = active ? a_sel : 4'd0;
  assign mul_b      = active ? b_sel : 4'd0;

endmodule
